// File: rtl/alu_exec_ctrl_pkg.sv
// Shared encodings for the Y86-64 execute stage: instruction/function codes,
// sequencer states, ALU operations and condition-code layout.
package alu_exec_ctrl_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] F_ADD = 4'h0;
  localparam logic [3:0] F_SUB = 4'h1;
  localparam logic [3:0] F_AND = 4'h2;
  localparam logic [3:0] F_XOR = 4'h3;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

  localparam int CC_ZF = 0;
  localparam int CC_SF = 1;
  localparam int CC_OF = 2;
  localparam logic [2:0] CC_RESET = 3'b001;

endpackage

// File: rtl/y86_cond_eval.sv
// Evaluates a Y86 branch/move condition code against the {OF,SF,ZF} flags.
module y86_cond_eval
  import alu_exec_ctrl_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd,
  output logic       bad_ifun
);

  logic zf, sf, of, lt;

  assign zf = cc[CC_ZF];
  assign sf = cc[CC_SF];
  assign of = cc[CC_OF];
  assign lt = sf ^ of;

  always_comb begin
    cnd      = 1'b0;
    bad_ifun = 1'b0;
    case (ifun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = lt | zf;
      C_L:      cnd = lt;
      C_E:      cnd = zf;
      C_NE:     cnd = ~zf;
      C_GE:     cnd = ~lt;
      C_G:      cnd = ~lt & ~zf;
      default:  bad_ifun = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Y86-64 execute-stage sequencer: latches one decoded instruction, computes
// valE on a shared ALU, maintains the condition codes and evaluates cnd.
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [N-1:0] valA,
  input  logic [N-1:0] valB,
  input  logic [N-1:0] valC,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] valE,
  output logic         cnd,
  output logic         err,
  output logic [2:0]   cc
);

  localparam logic [N-1:0] STACK_STEP = N'(8);

  state_e       state_q, state_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] vale_q, vale_d;
  logic         cnd_q, cnd_d;
  logic         err_q, err_d;
  logic [2:0]   cc_q, cc_d;

  logic [3:0]   ex_icode_q, ex_icode_d;
  logic [3:0]   ex_ifun_q, ex_ifun_d;
  logic [N-1:0] ex_vala_q, ex_vala_d;
  logic [N-1:0] ex_valb_q, ex_valb_d;
  logic [N-1:0] ex_valc_q, ex_valc_d;

  logic         accept;
  logic [N-1:0] alu_a, alu_b, alu_res;
  alu_op_e      alu_op;
  logic         op_err, cc_wr;
  logic [2:0]   new_cc;
  logic         ce_cnd, ce_bad, cnd_icode;
  logic         exe_cnd, exe_err;

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign valE      = vale_q;
  assign cnd       = cnd_q;
  assign err       = err_q;
  assign cc        = cc_q;

  // Operand latch: inputs are only looked at on the accept edge.
  always_comb begin
    ex_icode_d = ex_icode_q;
    ex_ifun_d  = ex_ifun_q;
    ex_vala_d  = ex_vala_q;
    ex_valb_d  = ex_valb_q;
    ex_valc_d  = ex_valc_q;
    if (accept) begin
      ex_icode_d = icode;
      ex_ifun_d  = ifun;
      ex_vala_d  = valA;
      ex_valb_d  = valB;
      ex_valc_d  = valC;
    end
  end

  always_ff @(posedge clk) begin
    ex_icode_q <= ex_icode_d;
    ex_ifun_q  <= ex_ifun_d;
    ex_vala_q  <= ex_vala_d;
    ex_valb_q  <= ex_valb_d;
    ex_valc_q  <= ex_valc_d;
  end

  // Operand select; unused slots stay zero so halt/nop/jXX/errors yield valE=0.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    op_err = 1'b0;
    cc_wr  = 1'b0;
    case (ex_icode_q)
      I_RRMOVQ: alu_a = ex_vala_q;
      I_IRMOVQ: alu_a = ex_valc_q;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = ex_valc_q;
        alu_b = ex_valb_q;
      end
      I_OPQ: begin
        if (ex_ifun_q <= F_XOR) begin
          alu_a  = ex_vala_q;
          alu_b  = ex_valb_q;
          alu_op = alu_op_e'(ex_ifun_q[1:0]);
          cc_wr  = 1'b1;
        end else begin
          op_err = 1'b1;
        end
      end
      I_CALL, I_PUSHQ: begin
        alu_a  = STACK_STEP;
        alu_b  = ex_valb_q;
        alu_op = ALU_SUB;
      end
      I_RET, I_POPQ: begin
        alu_a = STACK_STEP;
        alu_b = ex_valb_q;
      end
      I_HALT, I_NOP, I_JXX: ;
      default: op_err = 1'b1;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_ADD: alu_res = alu_b + alu_a;
      ALU_SUB: alu_res = alu_b - alu_a;
      ALU_AND: alu_res = alu_b & alu_a;
      default: alu_res = alu_b ^ alu_a;
    endcase
  end

  always_comb begin
    new_cc        = '0;
    new_cc[CC_ZF] = (alu_res == '0);
    new_cc[CC_SF] = alu_res[N-1];
    case (alu_op)
      ALU_ADD: new_cc[CC_OF] = (alu_a[N-1] == alu_b[N-1]) & (alu_res[N-1] != alu_b[N-1]);
      ALU_SUB: new_cc[CC_OF] = (alu_a[N-1] != alu_b[N-1]) & (alu_res[N-1] != alu_b[N-1]);
      default: new_cc[CC_OF] = 1'b0;
    endcase
  end

  y86_cond_eval u_cond (
    .cc       (cc_q),
    .ifun     (ex_ifun_q),
    .cnd      (ce_cnd),
    .bad_ifun (ce_bad)
  );

  assign cnd_icode = (ex_icode_q == I_RRMOVQ) | (ex_icode_q == I_JXX);
  assign exe_cnd   = cnd_icode & ce_cnd;
  assign exe_err   = op_err | (cnd_icode & ce_bad);

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    vale_d      = vale_q;
    cnd_d       = cnd_q;
    err_d       = err_q;
    cc_d        = cc_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_EXEC;
      ST_EXEC: begin
        vale_d      = alu_res;
        cnd_d       = exe_cnd;
        err_d       = exe_err;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
        if (cc_wr) cc_d = new_cc;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = in_valid ? ST_EXEC : ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      vale_q      <= '0;
      cnd_q       <= 1'b0;
      err_q       <= 1'b0;
      cc_q        <= CC_RESET;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      vale_q      <= vale_d;
      cnd_q       <= cnd_d;
      err_q       <= err_d;
      cc_q        <= cc_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl: directed Y86 sequences plus random
// instructions, checked against a behavioural execute-stage model.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  icode = '0, ifun = '0;
  logic [63:0] valA = '0, valB = '0, valC = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] valE;
  logic        cnd, err;
  logic [2:0]  cc;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.N(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .out_valid(out_valid), .out_ready(out_ready), .valE(valE),
    .cnd(cnd), .err(err), .cc(cc)
  );

  typedef struct {
    logic [63:0] vale;
    logic        cnd;
    logic        err;
    logic [2:0]  cc;
  } exp_t;

  exp_t    sbq[$];
  longint  lat_q[$];
  int      total = 0;
  int      bad = 0;
  longint  cyc = 0;
  int      rdy_mode = 0;
  logic    m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;
  logic    prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event not as expected (t=%0t)", nm, $time);
  endtask

  function automatic logic cond_of(input logic [3:0] f);
    logic lt;
    lt = (m_sf != m_of);
    case (f)
      4'd0: return 1'b1;
      4'd1: return lt || m_zf;
      4'd2: return lt;
      4'd3: return m_zf;
      4'd4: return !m_zf;
      4'd5: return !lt;
      4'd6: return !lt && !m_zf;
      default: return 1'b0;
    endcase
  endfunction

  // Reference: Y86 execute semantics with 65-bit signed arithmetic for overflow.
  task automatic model(input logic [3:0] ic, input logic [3:0] f,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    exp_t e;
    logic [64:0] w;
    e.vale = '0; e.cnd = 1'b0; e.err = 1'b0;
    case (ic)
      4'h0, 4'h1: ;
      4'h2: begin e.vale = a; e.cnd = cond_of(f); e.err = (f > 4'd6); end
      4'h3: e.vale = c;
      4'h4, 4'h5: e.vale = b + c;
      4'h6: begin
        if (f <= 4'd3) begin
          case (f)
            4'd0: begin w = {b[63], b} + {a[63], a}; e.vale = w[63:0]; m_of = (w[64] != w[63]); end
            4'd1: begin w = {b[63], b} - {a[63], a}; e.vale = w[63:0]; m_of = (w[64] != w[63]); end
            4'd2: begin e.vale = b & a; m_of = 1'b0; end
            default: begin e.vale = b ^ a; m_of = 1'b0; end
          endcase
          m_zf = (e.vale == 64'd0);
          m_sf = e.vale[63];
        end else begin
          e.err = 1'b1;
        end
      end
      4'h7: begin e.cnd = cond_of(f); e.err = (f > 4'd6); end
      4'h8, 4'hA: e.vale = b - 64'd8;
      4'h9, 4'hB: e.vale = b + 64'd8;
      default: e.err = 1'b1;
    endcase
    e.cc = {m_of, m_sf, m_zf};
    sbq.push_back(e);
  endtask

  task automatic issue(input logic [3:0] ic, input logic [3:0] f,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       output longint acc);
    int w;
    w = 0;
    acc = -1;
    icode = ic; ifun = f; valA = a; valB = b; valC = c;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    model(ic, f, a, b, c);
    acc = cyc + 1;
    lat_q.push_back(acc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    icode = 4'($urandom); ifun = 4'($urandom);
    valA = {$urandom, $urandom}; valB = {$urandom, $urandom}; valC = {$urandom, $urandom};
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: latency on each out_valid rise, result compare on each handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (out_valid && !prev_ov) begin
          if (lat_q.size() == 0) fail_now("unexpected_valid");
          else chk("latency", 64'(cyc - lat_q.pop_front()), 64'd1);
        end
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            fail_now("unexpected_output");
          end else begin
            e = sbq.pop_front();
            chk("valE", valE, e.vale);
            chk("cnd", 64'(cnd), 64'(e.cnd));
            chk("err", 64'(err), 64'(e.err));
            chk("cc", 64'(cc), 64'(e.cc));
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    longint acc, prev_acc;
    int n;
    logic [3:0] ric, rf;
    logic [63:0] ra, rb, rc;

    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_valE", valE, 64'd0);
    chk("rst_cnd", 64'(cnd), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_cc", 64'(cc), 64'b001);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;

    issue(4'h6, 4'h0, 64'd5, 64'd7, 64'd0, acc);
    issue(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, acc);
    issue(4'h7, 4'h2, 64'd0, 64'd0, 64'h40, acc);
    issue(4'h6, 4'h3, 64'hA5, 64'hA5, 64'd0, acc);
    issue(4'h2, 4'h3, 64'h55, 64'd0, 64'd0, acc);
    issue(4'h2, 4'h4, 64'h55, 64'd0, 64'd0, acc);
    issue(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, acc);
    issue(4'hB, 4'h0, 64'd0, 64'h100, 64'd0, acc);
    issue(4'hD, 4'h0, 64'd3, 64'd4, 64'd5, acc);
    issue(4'h6, 4'h5, 64'd3, 64'd4, 64'd0, acc);
    issue(4'h7, 4'h9, 64'd0, 64'd0, 64'd0, acc);

    // Back-to-back with the consumer always ready: one accept every 2 edges.
    issue(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, prev_acc);
    for (int i = 0; i < 5; i++) begin
      issue(4'h4, 4'h0, 64'd0, 64'(i * 16), 64'h1000, acc);
      chk("b2b_spacing", 64'(acc - prev_acc), 64'd2);
      prev_acc = acc;
    end

    // Consumer stall: result must hold and no new instruction accepted.
    repeat (3) @(posedge clk);
    rdy_mode = 2;
    @(posedge clk);
    #2;
    issue(4'h6, 4'h0, 64'd3, 64'd4, 64'd0, acc);
    fork
      begin
        longint acc_b;
        issue(4'h6, 4'h2, 64'hF0, 64'h3C, 64'd0, acc_b);
      end
    join_none
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_valE", valE, 64'd7);
      chk("stall_cnd", 64'(cnd), 64'd0);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    rdy_mode = 0;
    wait fork;

    // Reset while an instruction is in EXEC.
    repeat (4) @(posedge clk);
    #1;
    issue(4'h6, 4'h1, 64'd9, 64'd2, 64'd0, acc);
    reset = 1'b0;
    void'(sbq.pop_back());
    void'(lat_q.pop_back());
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_cc", 64'(cc), 64'b001);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_valE", valE, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    issue(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, acc);

    // Random instruction stream with a randomly stalling consumer.
    for (int i = 0; i < 250; i++) begin
      if (i % 25 == 0) rdy_mode = $urandom_range(0, 1);
      ric = 4'($urandom_range(0, 15));
      rf  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 6));
      ra  = {$urandom, $urandom};
      rb  = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
      rc  = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) ra = {1'b0, 63'($urandom)};
      issue(ric, rf, ra, rb, rc, acc);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    rdy_mode = 0;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() != 0) fail_now("drain_timeout");
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
